// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C subordinate interface.
package i2c_pkg;

    // Bus state as seen by the SCL-domain bit counter.
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } cc_state_t;

    // One frame is 8 data bits followed by the ACK slot.
    localparam int I2C_FRAME_LEN = 9;
    localparam int I2C_CNT_W     = 4;

endpackage : i2c_pkg

// File: rtl/clock_count.sv
// SCL-domain bit counter for the I2C subordinate interface.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no transfer in progress, count held at 0
//   ACTIVE | counting bits of the current frame, 0..FRAME_LEN-1
//
// count=0 is the MSB of the data byte, count=FRAME_LEN-1 is the ACK slot.
// START (including repeated START, i.e. start and stop together) restarts
// the frame; STOP returns to IDLE. Both strobes are level-sampled on the
// rising edge of scl, so holding either one keeps count at 0.
module clock_count
    import i2c_pkg::*;
#(
    parameter int FRAME_LEN = I2C_FRAME_LEN,
    parameter int CNT_W     = I2C_CNT_W
) (
    input  logic             scl,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

    cc_state_t        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state and next-count: start beats stop beats normal counting.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (start) begin
            state_d = ACTIVE;
            count_d = '0;
        end else if (stop) begin
            state_d = IDLE;
            count_d = '0;
        end else if (state_q == ACTIVE) begin
            count_d = (count_q == LAST_BIT) ? '0 : count_q + 1'b1;
        end else begin
            count_d = '0;
        end
    end

    // State and count registers with synchronous reset taking priority.
    always_ff @(posedge scl) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

    // The wrap compare is exact, so count never exceeds the ACK slot and
    // IDLE always presents bit 0.
    a_count_in_range : assert property (@(posedge scl) disable iff (rst)
        count_q <= LAST_BIT);
    a_idle_zero : assert property (@(posedge scl) disable iff (rst)
        (state_q == IDLE) |-> (count_q == '0));

endmodule : clock_count

// File: tb/tb_clock_count.sv
// Scoreboard bench for clock_count: stimulus pushes the expected count for
// each scl edge, a monitor pops and compares just after that edge.
module tb_clock_count;

    logic       scl = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] count;

    typedef struct {
        int    exp;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    clock_count dut (
        .scl   (scl),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .count (count)
    );

    always #5 scl = ~scl;

    // Drive one edge worth of inputs away from the rising edge and queue
    // the count expected after that edge.
    task automatic step(input logic r, input logic s, input logic p,
                        input int exp, input string name);
        exp_t e;
        @(negedge scl);
        rst   = r;
        start = s;
        stop  = p;
        e.exp  = exp;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: one expectation per rising edge, sampled 1 time unit later.
    initial begin
        forever begin
            @(posedge scl);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                n_checks++;
                if (count !== 4'(e.exp)) begin
                    n_errors++;
                    $display("FAIL %s: count=%0d expected=%0d", e.name, count, e.exp);
                end
            end
        end
    end

    initial begin
        int seq_a[12];
        int wait_cyc;
        seq_a = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 1, 2, 3};

        // Reset then idle.
        step(1, 0, 0, 0, "reset");
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, "idle_hold");

        // START and a full frame plus wrap.
        step(0, 1, 0, 0, "start");
        for (int i = 0; i < 12; i++) step(0, 0, 0, seq_a[i], "frame_count");

        // Advance to bit 5, then STOP and hold STOP.
        step(0, 0, 0, 4, "pre_stop");
        step(0, 0, 0, 5, "pre_stop");
        step(0, 0, 1, 0, "stop");
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, "stop_hold");
        step(0, 0, 0, 0, "idle_after_stop");
        step(0, 0, 0, 0, "idle_after_stop");

        // Repeated START: start and stop together.
        step(0, 1, 1, 0, "rep_start");
        for (int i = 1; i <= 3; i++) step(0, 0, 0, i, "after_rep_start");

        // START held for three edges.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, "start_held");
        step(0, 0, 0, 1, "start_release");

        // Reset mid-frame at bit 6 with start asserted.
        for (int i = 2; i <= 6; i++) step(0, 0, 0, i, "to_bit6");
        step(1, 1, 0, 0, "reset_mid");
        step(0, 0, 0, 0, "idle_after_reset");
        step(0, 0, 0, 0, "idle_after_reset");

        // START landing on the ACK slot restarts the frame.
        step(0, 1, 0, 0, "start2");
        for (int i = 1; i <= 8; i++) step(0, 0, 0, i, "to_ack");
        step(0, 1, 0, 0, "start_at_ack");
        step(0, 0, 0, 1, "after_start_at_ack");
        // STOP at the ACK slot.
        for (int i = 2; i <= 8; i++) step(0, 0, 0, i, "to_ack2");
        step(0, 0, 1, 0, "stop_at_ack");
        step(0, 0, 0, 0, "idle_after_ack_stop");

        // Let the monitor drain, bounded.
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 20) begin
            @(negedge scl);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_clock_count
